// File: rtl/bkm_pkg.sv
// Shared definitions for the BKM L-mode digit generator: digit encoding,
// controller state type and the default selection thresholds.
package bkm_pkg;

  typedef logic [1:0] digit_t;

  localparam digit_t D_ZERO = 2'b00;
  localparam digit_t D_POS  = 2'b01;
  localparam digit_t D_NEG  = 2'b10;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Thresholds are expressed in 1/16 units of the residual.
  localparam int TX_DEFAULT = 5;
  localparam int TY_DEFAULT = 8;
  localparam int SEL_FRAC   = 4;

  // A residual far below zero needs a +1 digit to pull it back, and vice versa.
  function automatic digit_t select_digit(input int r, input int t);
    digit_t d;
    if (r <= -t) begin
      d = D_POS;
    end else if (r >= t) begin
      d = D_NEG;
    end else begin
      d = D_ZERO;
    end
    return d;
  endfunction

endpackage

// File: rtl/bkm_l_digit_gen_if.sv
// E0 load stream plus digit output stream of the BKM L-mode digit generator.
// Optional macro BKM_LGEN_SAT_EN adds the sticky sat_flag signal.
interface bkm_l_digit_gen_if #(
  parameter int W = 32,
  parameter int N = 24
) ();
  import bkm_pkg::*;

  localparam int IDX_W = $clog2(N);

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     ex_in;
  logic [W-1:0]     ey_in;
  logic             out_valid;
  logic             out_ready;
  digit_t           d_x;
  digit_t           d_y;
  logic [IDX_W-1:0] d_idx;
  logic             d_last;
`ifdef BKM_LGEN_SAT_EN
  logic             sat_flag;
`endif

  // master: the digit generator itself (consumes E0, produces digits)
  modport master (
    input  in_valid, ex_in, ey_in, out_ready,
    output in_ready, out_valid, d_x, d_y, d_idx, d_last
`ifdef BKM_LGEN_SAT_EN
    , output sat_flag
`endif
  );

  modport slave (
    output in_valid, ex_in, ey_in, out_ready,
    input  in_ready, out_valid, d_x, d_y, d_idx, d_last
`ifdef BKM_LGEN_SAT_EN
    , input sat_flag
`endif
  );

endinterface

// File: rtl/bkm_l_digit_sel.sv
// Combinational BKM L-mode digit selection from truncated residual windows
// (sign, integer and 4 fractional bits, i.e. values in 1/16 units).
module bkm_l_digit_sel
  import bkm_pkg::*;
#(
  parameter int WIN = 8,
  parameter int TX  = TX_DEFAULT,
  parameter int TY  = TY_DEFAULT
) (
  input  logic signed [WIN-1:0] rx,
  input  logic signed [WIN-1:0] ry,
  output digit_t                d_x,
  output digit_t                d_y
);

  logic signed [WIN-1:0] win [2];
  digit_t                dsel [2];

  assign win[0] = rx;
  assign win[1] = ry;

  for (genvar gi = 0; gi < 2; gi++) begin : g_sel
    localparam int THR = (gi == 0) ? TX : TY;
    assign dsel[gi] = select_digit(int'(win[gi]), THR);
  end

  assign d_x = dsel[0];
  assign d_y = dsel[1];

endmodule

// File: rtl/bkm_l_digit_gen.sv
// Iterative BKM L-mode digit generator: loads E0 and streams N digit pairs.
// Optional macro BKM_LGEN_SAT_EN: saturating residual update and sat_flag.
module bkm_l_digit_gen
  import bkm_pkg::*;
#(
  parameter int W    = 32,
  parameter int FRAC = 28,
  parameter int N    = 24,
  parameter int TX   = TX_DEFAULT,
  parameter int TY   = TY_DEFAULT
) (
  input logic                clk,
  input logic                rst,
  bkm_l_digit_gen_if.master  bus
);

  localparam int IDX_W = $clog2(N);
  localparam int WIDE  = W + 3;
  localparam int WIN   = W - FRAC + SEL_FRAC;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic signed [WIDE-1:0] ONE = WIDE'(64'sd1 <<< FRAC);

  state_t                  state_reg;
  logic [IDX_W-1:0]        n_reg;
  digit_t                  dx_reg;
  digit_t                  dy_reg;
  logic signed [W-1:0]     ex_reg;
  logic signed [W-1:0]     ey_reg;

  logic signed [W-1:0]     r_cur [2];
  digit_t                  d_cur [2];
  logic signed [W-1:0]     r_upd [2];
  logic signed [W-1:0]     ex_next;
  logic signed [W-1:0]     ey_next;
  digit_t                  sel_dx;
  digit_t                  sel_dy;

  function automatic logic signed [WIDE-1:0] scale(input logic signed [WIDE-1:0] v,
                                                   input digit_t d);
    logic signed [WIDE-1:0] r;
    case (d)
      D_POS:   r = v;
      D_NEG:   r = -v;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign r_cur[0] = ex_reg;
  assign r_cur[1] = ey_reg;
  assign d_cur[0] = dx_reg;
  assign d_cur[1] = dy_reg;

`ifdef BKM_LGEN_SAT_EN
  localparam logic signed [WIDE-1:0] SAT_MAX = WIDE'((64'sd1 <<< (W - 1)) - 1);
  localparam logic signed [WIDE-1:0] SAT_MIN = WIDE'(-(64'sd1 <<< (W - 1)));
  logic upd_sat [2];
  logic sat_reg;
`endif

  // E_{n+1} = 2*(E_n + d_n + (d_n*E_n) >>> n), one lane per component.
  // Real lane: x*dx - y*dy; imag lane: y*dx + x*dy.
  for (genvar gi = 0; gi < 2; gi++) begin : g_comp
    logic signed [WIDE-1:0] own_ext;
    logic signed [WIDE-1:0] oth_ext;
    logic signed [WIDE-1:0] own_term;
    logic signed [WIDE-1:0] cross_term;
    logic signed [WIDE-1:0] prod;
    logic signed [WIDE-1:0] sum;
    logic signed [WIDE-1:0] dbl;

    assign own_ext    = WIDE'(r_cur[gi]);
    assign oth_ext    = WIDE'(r_cur[1 - gi]);
    assign own_term   = scale(own_ext, d_cur[0]);
    assign cross_term = scale(oth_ext, d_cur[1]);
    assign prod       = (gi == 0) ? (own_term - cross_term) : (own_term + cross_term);
    assign sum        = own_ext + scale(ONE, d_cur[gi]) + (prod >>> n_reg);
    // W+3 bits hold the doubled sum exactly for any W-bit residual.
    assign dbl        = sum <<< 1;

`ifdef BKM_LGEN_SAT_EN
    assign upd_sat[gi] = (dbl > SAT_MAX) || (dbl < SAT_MIN);
    assign r_upd[gi]   = (dbl > SAT_MAX) ? W'(SAT_MAX) :
                         (dbl < SAT_MIN) ? W'(SAT_MIN) : W'(dbl);
`else
    assign r_upd[gi]   = W'(dbl);
`endif
  end

  // In IDLE the selector sees E0, in RUN it sees E_{n+1}, so the digit for
  // the next output is registered alongside its residual.
  assign ex_next = (state_reg == IDLE) ? $signed(bus.ex_in) : r_upd[0];
  assign ey_next = (state_reg == IDLE) ? $signed(bus.ey_in) : r_upd[1];

  bkm_l_digit_sel #(
    .WIN (WIN),
    .TX  (TX),
    .TY  (TY)
  ) u_sel (
    .rx  (ex_next[W-1 -: WIN]),
    .ry  (ey_next[W-1 -: WIN]),
    .d_x (sel_dx),
    .d_y (sel_dy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      n_reg     <= '0;
      dx_reg    <= D_ZERO;
      dy_reg    <= D_ZERO;
      ex_reg    <= '0;
      ey_reg    <= '0;
`ifdef BKM_LGEN_SAT_EN
      sat_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            state_reg <= RUN;
            n_reg     <= '0;
            ex_reg    <= ex_next;
            ey_reg    <= ey_next;
            dx_reg    <= sel_dx;
            dy_reg    <= sel_dy;
`ifdef BKM_LGEN_SAT_EN
            sat_reg   <= 1'b0;
`endif
          end
        end
        RUN: begin
          if (bus.out_ready) begin
            if (n_reg == LAST_IDX) begin
              state_reg <= IDLE;
              n_reg     <= '0;
              dx_reg    <= D_ZERO;
              dy_reg    <= D_ZERO;
            end else begin
              n_reg     <= n_reg + IDX_W'(1);
              ex_reg    <= ex_next;
              ey_reg    <= ey_next;
              dx_reg    <= sel_dx;
              dy_reg    <= sel_dy;
`ifdef BKM_LGEN_SAT_EN
              sat_reg   <= sat_reg | upd_sat[0] | upd_sat[1];
`endif
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == RUN);
  assign bus.d_x       = dx_reg;
  assign bus.d_y       = dy_reg;
  assign bus.d_idx     = n_reg;
  assign bus.d_last    = (state_reg == RUN) && (n_reg == LAST_IDX);
`ifdef BKM_LGEN_SAT_EN
  assign bus.sat_flag  = sat_reg;
`endif

endmodule

// File: tb/tb_bkm_l_digit_gen.sv
// Directed bench for bkm_l_digit_gen (W=16, FRAC=12, N=4) with a scoreboard
// fed by an exact-integer model of the BKM L-mode recurrence.
module tb_bkm_l_digit_gen;
  import bkm_pkg::*;

  localparam int W     = 16;
  localparam int FRAC  = 12;
  localparam int N     = 4;
  localparam int IDX_W = $clog2(N);

  typedef struct {
    digit_t           dx;
    digit_t           dy;
    logic [IDX_W-1:0] idx;
    logic             last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  logic exp_sat;

  always #5 clk = ~clk;

  bkm_l_digit_gen_if #(.W(W), .N(N)) bus ();

  bkm_l_digit_gen #(
    .W(W), .FRAC(FRAC), .N(N), .TX(5), .TY(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic digit_t enc(input int v);
    return (v > 0) ? D_POS : (v < 0) ? D_NEG : D_ZERO;
  endfunction

  function automatic longint wrap_w(input longint v);
    longint m;
    m = v & ((64'sd1 <<< W) - 1);
    if (m >= (64'sd1 <<< (W - 1))) m = m - (64'sd1 <<< W);
    return m;
  endfunction

  // Reference recurrence on exact 64-bit integers; pushes the N expected digits.
  task automatic push_model(input longint x0, input longint y0);
    longint x, y, rx, ry, px, py, sx, sy;
    longint hi, lo;
    int     dxv, dyv;
    exp_t   e;
    hi = (64'sd1 <<< (W - 1)) - 1;
    lo = -(64'sd1 <<< (W - 1));
    x = x0;
    y = y0;
    exp_sat = 1'b0;
    for (int n = 0; n < N; n++) begin
      rx  = x >>> (FRAC - 4);
      ry  = y >>> (FRAC - 4);
      dxv = (rx <= -5) ? 1 : (rx >= 5) ? -1 : 0;
      dyv = (ry <= -8) ? 1 : (ry >= 8) ? -1 : 0;
      e.dx   = enc(dxv);
      e.dy   = enc(dyv);
      e.idx  = IDX_W'(n);
      e.last = (n == N - 1);
      sb.push_back(e);
      px = x * dxv - y * dyv;
      py = x * dyv + y * dxv;
      sx = 2 * (x + dxv * (64'sd1 <<< FRAC) + (px >>> n));
      sy = 2 * (y + dyv * (64'sd1 <<< FRAC) + (py >>> n));
      if (n < N - 1) begin
`ifdef BKM_LGEN_SAT_EN
        if (sx > hi || sx < lo || sy > hi || sy < lo) exp_sat = 1'b1;
        x = (sx > hi) ? hi : (sx < lo) ? lo : sx;
        y = (sy > hi) ? hi : (sy < lo) ? lo : sy;
`else
        x = wrap_w(sx);
        y = wrap_w(sy);
`endif
      end
    end
  endtask

  task automatic load(input longint x, input longint y);
    check("load_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.ex_in    = W'(x);
    bus.ey_in    = W'(y);
    push_model(x, y);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("load_out_valid", 32'(bus.out_valid), 32'd1);
  endtask

  task automatic step();
    exp_t e;
    int   w = 0;
    while (bus.out_valid !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (bus.out_valid !== 1'b1) begin
      checks++;
      errors++;
      $error("FAIL step_timeout observed out_valid=%b expected 1", bus.out_valid);
      sb.delete();
      return;
    end
    e = sb.pop_front();
    check($sformatf("d_x[%0d]", e.idx), 32'(bus.d_x), 32'(e.dx));
    check($sformatf("d_y[%0d]", e.idx), 32'(bus.d_y), 32'(e.dy));
    check("d_idx", 32'(bus.d_idx), 32'(e.idx));
    check("d_last", 32'(bus.d_last), 32'(e.last));
    $display("digit idx=%0d d_x=%b d_y=%b last=%b", bus.d_idx, bus.d_x, bus.d_y, bus.d_last);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic drain();
    while (sb.size() > 0) step();
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);
    check("idle_out_valid", 32'(bus.out_valid), 32'd0);
`ifdef BKM_LGEN_SAT_EN
    check("sat_flag", 32'(bus.sat_flag), 32'(exp_sat));
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.ex_in     = '0;
    bus.ey_in     = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_d_x", 32'(bus.d_x), 32'd0);
    check("rst_d_y", 32'(bus.d_y), 32'd0);
    check("rst_d_idx", 32'(bus.d_idx), 32'd0);
    check("rst_d_last", 32'(bus.d_last), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: zero input; out_ready in IDLE must do nothing
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("idle_ready_noop", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
    load(0, 0);
    drain();

    // 2: real step, E0 = -0.5
    load(-2048, 0);
    check("t2_n0_d_x", 32'(bus.d_x), 32'(D_POS));
    check("t2_n0_d_y", 32'(bus.d_y), 32'(D_ZERO));
    drain();

    // 3/4: imag step, E0 = 0.75j, then backpressure at n=1
    load(0, 3072);
    check("t3_n0_d_x", 32'(bus.d_x), 32'(D_ZERO));
    check("t3_n0_d_y", 32'(bus.d_y), 32'(D_NEG));
    step();
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_d_x", 32'(bus.d_x), 32'(D_NEG));
      check("bp_d_y", 32'(bus.d_y), 32'(D_POS));
      check("bp_d_idx", 32'(bus.d_idx), 32'd1);
      @(negedge clk);
    end
    step();
    check("bp_advanced_idx", 32'(bus.d_idx), 32'd2);
    drain();

    // 5: input offered while busy is ignored, then reset mid-run
    load(0, 3072);
    step();
    step();
    bus.in_valid = 1'b1;
    bus.ex_in    = 16'h1234;
    bus.ey_in    = 16'hC000;
    repeat (2) begin
      @(negedge clk);
      check("busy_in_ready", 32'(bus.in_ready), 32'd0);
      check("busy_d_idx", 32'(bus.d_idx), 32'd2);
      check("busy_d_x", 32'(bus.d_x), 32'(sb[0].dx));
      check("busy_d_y", 32'(bus.d_y), 32'(sb[0].dy));
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_d_x", 32'(bus.d_x), 32'd0);
    check("mid_rst_d_y", 32'(bus.d_y), 32'd0);
    check("mid_rst_d_last", 32'(bus.d_last), 32'd0);
    load(-2048, 0);
    check("restart_idx", 32'(bus.d_idx), 32'd0);
    drain();

    // 6: large residuals that overflow the W-bit update
    load(32358, 0);
    drain();
    load(32358, 32358);
    drain();
    load(-32768, 32767);
    drain();

    // a few arbitrary operands
    for (int k = 0; k < 4; k++) begin
      load(longint'($urandom_range(65535)) - 32768, longint'($urandom_range(65535)) - 32768);
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
